// File: rtl/picorv32_run_ctrl_if.sv
// Program-stream and instruction-memory write-port bundle for picorv32_run_ctrl.
// The master side is the host/loader; the slave side is the run controller.
// The controller accepts the stream and drives the memory write port.
interface picorv32_run_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  mem_en, mem_wen, mem_addr, mem_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output mem_en, mem_wen, mem_addr, mem_data
  );
endinterface

// File: rtl/picorv32_run_ctrl.sv
// picorv32_run_ctrl: host-side sequencer for the PicoRV32 harness.
// It streams a program into instruction memory, holds the core in reset,
// then runs the core until it traps or reaches the cycle budget.
// Optional build macro PICORV_RUN_CTRL_TRIG_COUNT_EN enables the decode-trigger
// counter. When the macro is undefined, trig_count reads 0.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// LOAD  | accepting program words, writing them to instruction memory
// HOLD  | program loaded, core_resetn kept low for RESET_HOLD cycles
// RUN   | core released and clocked, counting cycles
// DONE  | run finished (trap/timeout/overflow), core frozen for inspection
module picorv32_run_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 32,
  parameter int TRIG_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cycle_limit,
  picorv32_run_ctrl_if.slave bus,
  output logic              core_resetn,
  output logic              core_clk_en,
  input  logic              core_trap,
  input  logic              core_dec_trigger,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycles,
  output logic [TRIG_W-1:0] trig_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_TRAP = 2'b01;
  localparam logic [1:0] ST_TOUT = 2'b10;
  localparam logic [1:0] ST_OVF  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]        status_q, status_nxt;
  logic [CNT_W-1:0]  cycles_q, cycles_nxt;
  logic              s_ready_q, s_ready_nxt;
  logic              mem_en_q, mem_en_nxt;
  logic [3:0]        mem_wen_q, mem_wen_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [31:0]       mem_data_q, mem_data_nxt;
  logic              core_resetn_q, core_resetn_nxt;
  logic              core_clk_en_q, core_clk_en_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              clr;
  logic              beat;

  // State and every registered output; outputs follow the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      hold_cnt      <= '0;
      status_q      <= ST_NONE;
      cycles_q      <= '0;
      s_ready_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_wen_q     <= 4'h0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      core_resetn_q <= 1'b0;
      core_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      hold_cnt      <= hold_nxt;
      status_q      <= status_nxt;
      cycles_q      <= cycles_nxt;
      s_ready_q     <= s_ready_nxt;
      mem_en_q      <= mem_en_nxt;
      mem_wen_q     <= mem_wen_nxt;
      mem_addr_q    <= mem_addr_nxt;
      mem_data_q    <= mem_data_nxt;
      core_resetn_q <= core_resetn_nxt;
      core_clk_en_q <= core_clk_en_nxt;
      busy_q        <= busy_nxt;
      done_q        <= done_nxt;
    end
  end

  // Next-state, datapath and output decode; abort overrides everything.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    hold_nxt     = hold_cnt;
    status_nxt   = status_q;
    cycles_nxt   = cycles_q;
    mem_en_nxt   = 1'b0;
    mem_wen_nxt  = 4'h0;
    mem_addr_nxt = mem_addr_q;
    mem_data_nxt = mem_data_q;
    clr          = 1'b0;
    beat         = bus.s_valid && s_ready_q;

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt  = LOAD;
            wr_ptr_nxt = '0;
            cycles_nxt = '0;
            status_nxt = ST_NONE;
            clr        = 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            mem_en_nxt   = 1'b1;
            mem_wen_nxt  = 4'hF;
            mem_addr_nxt = wr_ptr;
            mem_data_nxt = bus.s_data;
            wr_ptr_nxt   = wr_ptr + 1'b1;
            if (bus.s_last) begin
              state_nxt = HOLD;
              hold_nxt  = HOLD_INIT;
            end else if (wr_ptr == '1) begin
              // Memory is full and the program is still going: never run it.
              state_nxt  = DONE;
              status_nxt = ST_OVF;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state_nxt = RUN;
          end else begin
            hold_nxt = hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (cycles_q != '1) begin
            cycles_nxt = cycles_q + 1'b1;
          end
          if (core_trap) begin
            state_nxt  = DONE;
            status_nxt = ST_TRAP;
          end else if ((cycle_limit != '0) && (cycles_q + CNT_W'(1) == cycle_limit)) begin
            state_nxt  = DONE;
            status_nxt = ST_TOUT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    s_ready_nxt     = (state_nxt == LOAD);
    core_clk_en_nxt = (state_nxt == RUN);
    busy_nxt        = (state_nxt == LOAD) || (state_nxt == HOLD) || (state_nxt == RUN);
    done_nxt        = (state_nxt == DONE);
    // DONE keeps whatever reset level the core had: released after a run,
    // still low after a load overflow.
    case (state_nxt)
      RUN:     core_resetn_nxt = 1'b1;
      DONE:    core_resetn_nxt = core_resetn_q;
      default: core_resetn_nxt = 1'b0;
    endcase
  end

`ifdef PICORV_RUN_CTRL_TRIG_COUNT_EN
  logic [TRIG_W-1:0] trig_q;
  logic              trig_inc;

  assign trig_inc = (state == RUN) && !abort && core_dec_trigger;

  // Decode-trigger counter: cleared on start, saturates at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_q <= '0;
    end else if (clr) begin
      trig_q <= '0;
    end else if (trig_inc && (trig_q != '1)) begin
      trig_q <= trig_q + 1'b1;
    end
  end

  assign trig_count = trig_q;
`else
  logic unused_trig;
  assign unused_trig = core_dec_trigger | clr;
  assign trig_count  = '0;
`endif

  assign bus.s_ready  = s_ready_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_wen  = mem_wen_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign core_resetn  = core_resetn_q;
  assign core_clk_en  = core_clk_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycles       = cycles_q;

endmodule

// File: tb/tb_picorv32_run_ctrl.sv
// Self-checking bench for picorv32_run_ctrl (ADDR_W=4 build, RESET_HOLD=4).
// Expected run results are derived from the trap cycle, cycle budget and abort
// point with plain arithmetic; program writes are checked against the word list.
module tb_picorv32_run_ctrl;
  localparam int ADDR_W     = 4;
  localparam int RESET_HOLD = 4;
  localparam int CNT_W      = 32;
  localparam int TRIG_W     = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  cycle_limit = '0;
  logic              core_resetn, core_clk_en;
  logic              core_trap = 1'b0;
  logic              core_dec_trigger = 1'b0;
  logic              busy, done;
  logic [1:0]        status;
  logic [CNT_W-1:0]  cycles;
  logic [TRIG_W-1:0] trig_count;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] prog [0:31];
  bit          trig_pat [0:63];

  picorv32_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  picorv32_run_ctrl #(
    .ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W), .TRIG_W(TRIG_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cycle_limit(cycle_limit), .bus(bus),
    .core_resetn(core_resetn), .core_clk_en(core_clk_en),
    .core_trap(core_trap), .core_dec_trigger(core_dec_trigger),
    .busy(busy), .done(done), .status(status), .cycles(cycles),
    .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_s_ready", bus.s_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_cycles_clr", cycles, 0);
    chk("start_status_clr", status, 0);
    chk("start_trig_clr", trig_count, 0);
    chk("start_core_resetn", core_resetn, 0);
  endtask

  // Stream n words from prog[]; each accepted beat must show up as a write
  // one cycle later at address = beat index.
  task automatic load_prog(input int n, input bit with_last, input bit gaps);
    int h;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bus.s_valid = 1'b0;
        tick();
        chk("gap_mem_en", bus.mem_en, 0);
        chk("gap_mem_wen", bus.mem_wen, 0);
      end
      chk("load_s_ready", bus.s_ready, 1);
      bus.s_valid = 1'b1;
      bus.s_data  = prog[i];
      bus.s_last  = with_last && (i == n - 1);
      tick();
      chk("wr_mem_en", bus.mem_en, 1);
      chk("wr_mem_wen", bus.mem_wen, 4'hF);
      chk("wr_mem_addr", bus.mem_addr, i[ADDR_W-1:0]);
      chk("wr_mem_data", bus.mem_data, prog[i]);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (with_last) begin
      h = 0;
      while (!core_clk_en && h < 50) begin
        chk("hold_core_resetn", core_resetn, 0);
        h++;
        tick();
      end
      chk("hold_len", h, RESET_HOLD);
      chk("run_core_resetn", core_resetn, 1);
      chk("run_entry_cycles", cycles, 0);
    end
  endtask

  task automatic fill_prog(input int n);
    for (int i = 0; i < n; i++) prog[i] = $urandom;
  endtask

  // Run from the first RUN cycle. trap_at/abort_after of 0 mean "never".
  task automatic run_core(input int limit, input int trap_at, input int abort_after,
                          input bit rnd_trig, input int start_at);
    int end_k, exp_trig, k;
    logic [1:0] exp_st;
    bit aborted;
    end_k  = 60;
    exp_st = 2'b00;
    if (trap_at > 0) begin end_k = trap_at; exp_st = 2'b01; end
    if (limit != 0 && limit < end_k) begin end_k = limit; exp_st = 2'b10; end
    aborted = (abort_after > 0) && (abort_after < end_k);
    if (aborted) begin end_k = abort_after; exp_st = 2'b00; end
    exp_trig = 0;
    for (int j = 0; j < 64; j++) begin
      trig_pat[j] = rnd_trig ? bit'($urandom_range(0, 1)) : (j == 2 || j == 4 || j == 6);
      if (j >= 1 && j <= end_k && trig_pat[j]) exp_trig++;
    end
`ifndef PICORV_RUN_CTRL_TRIG_COUNT_EN
    exp_trig = 0;
`endif
    cycle_limit = limit;
    k = 0;
    while (k < end_k) begin
      k++;
      core_trap        = (k == trap_at);
      core_dec_trigger = trig_pat[k];
      start            = (k == start_at);
      tick();
      if (k < end_k) chk("run_not_done", done, 0);
    end
    core_trap = 1'b0;
    core_dec_trigger = 1'b0;
    start = 1'b0;
    if (aborted) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_core_resetn", core_resetn, 0);
      chk("abort_core_clk_en", core_clk_en, 0);
      chk("abort_s_ready", bus.s_ready, 0);
      chk("abort_cycles", cycles, end_k);
    end else begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_core_clk_en", core_clk_en, 0);
      chk("end_core_resetn", core_resetn, 1);
      chk("end_cycles", cycles, end_k);
    end
    chk("end_status", status, exp_st);
    chk("end_trig_count", trig_count, exp_trig);
  endtask

  initial begin
    int n, lim, trp;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset values
    #2 resetn = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_core_resetn", core_resetn, 0);
    chk("rst_core_clk_en", core_clk_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_trig", trig_count, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("idle_core_resetn", core_resetn, 0);
    chk("idle_busy", busy, 0);

    // Directed program, trap at RUN cycle 10, three trigger pulses
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0000_0013;
    prog[2] = 32'h0010_0073;
    do_start();
    load_prog(3, 1'b1, 1'b1);
    run_core(0, 10, 0, 1'b0, 0);

    // Timeout at 5, then trap on the same final cycle
    do_start(); fill_prog(4); load_prog(4, 1'b1, 1'b0);
    run_core(5, 0, 0, 1'b1, 2);
    do_start(); fill_prog(2); load_prog(2, 1'b1, 1'b1);
    run_core(5, 5, 0, 1'b1, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      n   = $urandom_range(1, 6);
      lim = $urandom_range(0, 30);
      trp = $urandom_range(0, 30);
      if (lim == 0 && trp == 0) trp = $urandom_range(1, 30);
      do_start(); fill_prog(n); load_prog(n, 1'b1, bit'($urandom_range(0, 1)));
      run_core(lim, trp, 0, 1'b1, $urandom_range(1, 4));
    end

    // Abort at RUN cycle 7, counters retained, then restart from zero
    do_start(); fill_prog(3); load_prog(3, 1'b1, 1'b0);
    run_core(0, 20, 7, 1'b1, 0);
    tick();
    chk("idle_cycles_hold", cycles, 7);
    do_start(); fill_prog(2); load_prog(2, 1'b1, 1'b0);
    run_core(3, 0, 0, 1'b1, 0);

    // Overflow: 16 words, no s_last
    do_start(); fill_prog(16); load_prog(16, 1'b0, 1'b1);
    chk("ovf_done", done, 1);
    chk("ovf_status", status, 2'b11);
    chk("ovf_s_ready", bus.s_ready, 0);
    chk("ovf_core_resetn", core_resetn, 0);
    chk("ovf_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf_resetn_held", core_resetn, 0);
      chk("ovf_clk_en_held", core_clk_en, 0);
      chk("ovf_no_write", bus.mem_en, 0);
    end

    // start and abort together in DONE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_done", done, 0);
    chk("sa_s_ready", bus.s_ready, 0);
    chk("sa_status_kept", status, 2'b11);

    // Abort during LOAD with a beat presented: no write happens
    do_start(); fill_prog(1); load_prog(1, 1'b0, 1'b0);
    bus.s_valid = 1'b1; bus.s_data = 32'hDEAD_BEEF; abort = 1'b1;
    tick();
    bus.s_valid = 1'b0; abort = 1'b0;
    chk("ldabort_mem_en", bus.mem_en, 0);
    chk("ldabort_s_ready", bus.s_ready, 0);
    chk("ldabort_busy", busy, 0);

    // Async reset mid-load, then a fresh load starts again at address 0
    do_start(); fill_prog(2); load_prog(2, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_s_ready", bus.s_ready, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_busy", busy, 0);
    tick();
    resetn = 1'b1;
    tick();
    do_start(); fill_prog(3); load_prog(3, 1'b1, 1'b1);
    run_core(4, 0, 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
